// File: rtl/uart_doc_loader_if.sv
// Bundle between the UART document loader and its consumer: receive line,
// loader controls, and the document write request.
interface uart_doc_loader_if;
   logic       RsRx;
   logic       load_en;
   logic       home;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       frame_err;

   modport master (
      input  RsRx, load_en, home,
      output wr_en, wr_addr, wr_data, busy, frame_err
   );

   modport slave (
      output RsRx, load_en, home,
      input  wr_en, wr_addr, wr_data, busy, frame_err
   );
endinterface

// File: rtl/uart_doc_loader.sv
// UART receiver that turns incoming text into {row,col} document RAM writes.
// Define UART_RX_PARITY_EN for 8E1 frames; default build is 8N1.
module uart_doc_loader #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned COLS     = 20,
   parameter int unsigned ROWS     = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_doc_loader_if.master      doc
);
   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned CW  = $clog2(DIV);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WRITE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [3:0]    row_q, row_d;
   logic [4:0]    col_q, col_d;
   logic          wr_en_q, wr_en_d;
   logic [8:0]    wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          nl_q, nl_d;
   logic          ferr_q, ferr_d;
   logic          busy_q;
   logic [1:0]    sync_q;
   logic          prev_q;

   logic rx_c, fall_c, half_c, full_c, bad_c;

   assign rx_c   = sync_q[1];
   assign fall_c = prev_q & ~rx_c;
   assign half_c = (cnt_q == CW'(DIV / 2 - 1));
   assign full_c = (cnt_q == CW'(DIV - 1));
`ifdef UART_RX_PARITY_EN
   assign bad_c  = ~rx_c | par_q;
`else
   assign bad_c  = ~rx_c;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         row_q     <= '0;
         col_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         nl_q      <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
         sync_q    <= 2'b11;
         prev_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         row_q     <= row_d;
         col_q     <= col_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         nl_q      <= nl_d;
         ferr_q    <= ferr_d;
         busy_q    <= (state_d != IDLE);
         sync_q    <= {sync_q[0], doc.RsRx};
         prev_q    <= rx_c;
      end
   end

   // Write request is registered on the stop-sample edge so wr_en coincides with WRITE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      nl_d      = 1'b0;
      ferr_d    = 1'b0;
      row_d     = row_q;
      col_d     = col_q;

      unique case (state_q)
         IDLE: begin
            if (fall_c) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (half_c) begin
               cnt_d   = '0;
               bit_d   = '0;
               par_d   = 1'b0;
               state_d = rx_c ? IDLE : DATA;
            end
         end
         DATA: begin
            if (full_c) begin
               cnt_d   = '0;
               shift_d = {rx_c, shift_q[7:1]};
               par_d   = par_q ^ rx_c;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (full_c) begin
               cnt_d   = '0;
               par_d   = par_q ^ rx_c;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (full_c) begin
               cnt_d = '0;
               if (bad_c) begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WRITE;
                  if (doc.load_en) begin
                     if (shift_q >= 8'h20 && shift_q <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {row_q, col_q};
                        wr_data_d = shift_q;
                     end else if (shift_q == 8'h0A) begin
                        nl_d = 1'b1;
                     end
                  end
               end
            end
         end
         WRITE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Cursor moves after the write; home overrides advance and newline.
      if (doc.home) begin
         row_d = '0;
         col_d = '0;
      end else if (state_q == WRITE && (wr_en_q || nl_q)) begin
         if (nl_q || col_q == 5'(COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == 4'(ROWS - 1)) ? 4'd0 : row_q + 4'd1;
         end else begin
            col_d = col_q + 5'd1;
         end
      end
   end

   assign doc.wr_en     = wr_en_q;
   assign doc.wr_addr   = wr_addr_q;
   assign doc.wr_data   = wr_data_q;
   assign doc.busy      = busy_q;
   assign doc.frame_err = ferr_q;
endmodule
